// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-port arbiter sharing one 16-bit SDRAM Avalon-MM slave.
// Build option SDRAM_ARB_RR_EN: round-robin tie-break; undefined: port 0 wins every tie.
// Ports: clk, reset (async, active-low); p0_*/p1_* requester commands and responses
// (port 0 geometry fetch, port 1 framebuffer writeback); sdram_* slave command and
// response; rd_orphan sticky flag for a returned beat with no pending read.
module sdram_arbiter #(
    parameter int MAX_PENDING = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_read,
    input  logic        p0_write,
    input  logic [24:0] p0_address,
    input  logic [1:0]  p0_byteenable,
    input  logic [15:0] p0_writedata,
    output logic        p0_waitrequest,
    output logic [15:0] p0_readdata,
    output logic        p0_readdatavalid,
    input  logic        p1_read,
    input  logic        p1_write,
    input  logic [24:0] p1_address,
    input  logic [1:0]  p1_byteenable,
    input  logic [15:0] p1_writedata,
    output logic        p1_waitrequest,
    output logic [15:0] p1_readdata,
    output logic        p1_readdatavalid,
    output logic [24:0] sdram_address,
    output logic [1:0]  sdram_byteenable,
    output logic [15:0] sdram_writedata,
    output logic        sdram_read,
    output logic        sdram_write,
    output logic        sdram_chipselect,
    input  logic [15:0] sdram_readdata,
    input  logic        sdram_waitrequest,
    input  logic        sdram_readdatavalid,
    output logic        rd_orphan
);
    localparam int PW = $clog2(MAX_PENDING);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(MAX_PENDING);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t        state, state_next;
    logic          owner, last_grant, winner, active, tie_pick;
    logic          c0, c1, full, sel_write, accept, push, pop, head;
    logic          fifo [MAX_PENDING];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;

    // A full owner FIFO only masks reads; writes still compete.
    assign full = count == FULL_CNT;
    assign c0   = p0_write | (p0_read & ~full);
    assign c1   = p1_write | (p1_read & ~full);

`ifdef SDRAM_ARB_RR_EN
    assign tie_pick = ~last_grant;
`else
    // last_grant is still tracked, but a tie always goes to port 0.
    assign tie_pick = last_grant & 1'b0;
`endif

    // HOLD pins the grant to owner until the stalled command is accepted.
    // Reset gates the command so outputs idle regardless of requester inputs.
    always_comb begin
        winner     = owner;
        active     = 1'b0;
        state_next = IDLE;
        if (state == IDLE)
            winner = (c0 & c1) ? tie_pick : c1;
        active = reset & ((state == HOLD) | c0 | c1);
        if (active & sdram_waitrequest)
            state_next = HOLD;
    end

    // Read+write on one port is treated as a write.
    assign sel_write        = winner ? p1_write : p0_write;
    assign sdram_chipselect = active;
    assign sdram_write      = active & sel_write;
    assign sdram_read       = active & ~sel_write;
    assign sdram_address    = active ? (winner ? p1_address : p0_address) : '0;
    assign sdram_byteenable = active ? (winner ? p1_byteenable : p0_byteenable) : '0;
    assign sdram_writedata  = active ? (winner ? p1_writedata : p0_writedata) : '0;

    assign accept         = active & ~sdram_waitrequest;
    assign push           = accept & ~sel_write;
    assign pop            = reset & sdram_readdatavalid & (count != '0);
    assign head           = fifo[rd_ptr];
    assign p0_waitrequest = ~(accept & ~winner);
    assign p1_waitrequest = ~(accept & winner);

    assign p0_readdata      = sdram_readdata;
    assign p1_readdata      = sdram_readdata;
    assign p0_readdatavalid = pop & ~head;
    assign p1_readdatavalid = pop & head;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            rd_orphan  <= 1'b0;
        end else begin
            state <= state_next;
            if (active)
                owner <= winner;
            if (accept)
                last_grant <= winner;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            if (sdram_readdatavalid && count == '0)
                rd_orphan <= 1'b1;
        end
    end

    // Owner storage needs no reset: count and pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push)
            fifo[wr_ptr] <= winner;
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed scenarios plus randomized traffic checked against a queue-based model.
module tb_sdram_arbiter;
    localparam int MP = 4;
`ifdef SDRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        p0_read = 0, p0_write = 0, p1_read = 0, p1_write = 0;
    logic [24:0] p0_address = '0, p1_address = '0;
    logic [1:0]  p0_byteenable = '0, p1_byteenable = '0;
    logic [15:0] p0_writedata = '0, p1_writedata = '0;
    logic        p0_waitrequest, p1_waitrequest, p0_readdatavalid, p1_readdatavalid;
    logic [15:0] p0_readdata, p1_readdata;
    logic [24:0] sdram_address;
    logic [1:0]  sdram_byteenable;
    logic [15:0] sdram_writedata;
    logic        sdram_read, sdram_write, sdram_chipselect;
    logic [15:0] sdram_readdata = '0;
    logic        sdram_waitrequest = 0, sdram_readdatavalid = 0;
    logic        rd_orphan;

    int checks = 0;
    int passed = 0;

    // Reference model: pending read owners in issue order, grant history, hold lock.
    bit m_q[$];
    bit m_last, m_hold, m_owner, m_orphan;
    bit e_act, e_win, e_wr;

    sdram_arbiter #(.MAX_PENDING(MP)) dut (
        .clk(clk), .reset(reset),
        .p0_read(p0_read), .p0_write(p0_write), .p0_address(p0_address),
        .p0_byteenable(p0_byteenable), .p0_writedata(p0_writedata),
        .p0_waitrequest(p0_waitrequest), .p0_readdata(p0_readdata),
        .p0_readdatavalid(p0_readdatavalid),
        .p1_read(p1_read), .p1_write(p1_write), .p1_address(p1_address),
        .p1_byteenable(p1_byteenable), .p1_writedata(p1_writedata),
        .p1_waitrequest(p1_waitrequest), .p1_readdata(p1_readdata),
        .p1_readdatavalid(p1_readdatavalid),
        .sdram_address(sdram_address), .sdram_byteenable(sdram_byteenable),
        .sdram_writedata(sdram_writedata), .sdram_read(sdram_read),
        .sdram_write(sdram_write), .sdram_chipselect(sdram_chipselect),
        .sdram_readdata(sdram_readdata), .sdram_waitrequest(sdram_waitrequest),
        .sdram_readdatavalid(sdram_readdatavalid), .rd_orphan(rd_orphan)
    );

    always #5 clk = ~clk;

    function automatic void m_rst();
        m_q.delete();
        m_last   = 1'b1;
        m_hold   = 1'b0;
        m_owner  = 1'b0;
        m_orphan = 1'b0;
    endfunction

    // Who drives the slave this cycle, from the arbitration rules and current inputs.
    function automatic void m_eval();
        bit full, c0, c1;
        full = m_q.size() >= MP;
        c0 = p0_write || (p0_read && !full);
        c1 = p1_write || (p1_read && !full);
        if (m_hold) begin
            e_act = 1'b1;
            e_win = m_owner;
        end else begin
            e_act = c0 || c1;
            e_win = (c0 && c1) ? (RR ? !m_last : 1'b0) : c1;
        end
        e_wr  = e_win ? p1_write : p0_write;
        e_act = e_act && reset;
    endfunction

    // Advance one clock, updating the model with what the edge commits.
    task automatic tick();
        m_eval();
        @(posedge clk);
        if (!reset) begin
            m_rst();
        end else begin
            if (sdram_readdatavalid) begin
                if (m_q.size() > 0) void'(m_q.pop_front());
                else m_orphan = 1'b1;
            end
            if (e_act && !sdram_waitrequest) begin
                m_last = e_win;
                if (!e_wr) m_q.push_back(e_win);
            end
            m_hold = e_act && sdram_waitrequest;
            if (m_hold) m_owner = e_win;
        end
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 32 && m_q.size() > 0; i++) begin
            sdram_readdatavalid = 1'b1;
            tick();
        end
        sdram_readdatavalid = 1'b0;
    endtask

    task automatic test_reset();
        m_rst();
        #1;
        {p0_read, p0_write, p1_read, p1_write} = 4'hF;
        p0_address = '1; p1_address = '1; p0_writedata = '1; p1_writedata = '1;
        sdram_readdatavalid = 1'b1;
        #1;
        checks++;
        if ({sdram_chipselect, sdram_read, sdram_write, sdram_address, sdram_byteenable, sdram_writedata} !== '0)
            $display("FAIL reset_cmd: got cs=%b rd=%b wr=%b addr=%h expected all zero", sdram_chipselect, sdram_read, sdram_write, sdram_address);
        else passed++;
        checks++;
        if ({p0_waitrequest, p1_waitrequest} !== 2'b11)
            $display("FAIL reset_wait: got %b expected 11", {p0_waitrequest, p1_waitrequest});
        else passed++;
        checks++;
        if ({p0_readdatavalid, p1_readdatavalid, rd_orphan} !== 3'b000)
            $display("FAIL reset_rdv: got %b expected 000", {p0_readdatavalid, p1_readdatavalid, rd_orphan});
        else passed++;
        tick();
        tick();
        {p0_read, p0_write, p1_read, p1_write} = 4'h0;
        p0_address = '0; p1_address = '0; p0_writedata = '0; p1_writedata = '0;
        sdram_readdatavalid = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if ({sdram_chipselect, p0_waitrequest, p1_waitrequest, rd_orphan} !== 4'b0110)
            $display("FAIL idle_after_reset: got %b expected 0110", {sdram_chipselect, p0_waitrequest, p1_waitrequest, rd_orphan});
        else passed++;
        tick();
    endtask

    task automatic test_basic();
        p0_write = 1; p0_address = '0; p0_writedata = 16'd36; p0_byteenable = 2'b11;
        p1_read = 1; p1_address = '0;
        #1;
        checks++;
        if ({sdram_write, sdram_read, sdram_writedata} !== {2'b10, 16'd36})
            $display("FAIL basic_c0_cmd: got wr=%b rd=%b data=%0d expected wr=1 rd=0 data=36", sdram_write, sdram_read, sdram_writedata);
        else passed++;
        checks++;
        if ({p0_waitrequest, p1_waitrequest} !== 2'b01)
            $display("FAIL basic_c0_wait: got %b expected 01", {p0_waitrequest, p1_waitrequest});
        else passed++;
        tick();
        p0_write = 0;
        #1;
        checks++;
        if ({sdram_read, sdram_write, p0_waitrequest, p1_waitrequest} !== 4'b1010)
            $display("FAIL basic_c1: got rd/wr/w0/w1=%b expected 1010", {sdram_read, sdram_write, p0_waitrequest, p1_waitrequest});
        else passed++;
        tick();
        p1_read = 0; sdram_readdata = 16'd36; sdram_readdatavalid = 1;
        #1;
        checks++;
        if ({p0_readdatavalid, p1_readdatavalid, p1_readdata} !== {2'b01, 16'd36})
            $display("FAIL basic_ret: got v0=%b v1=%b data=%0d expected v0=0 v1=1 data=36", p0_readdatavalid, p1_readdatavalid, p1_readdata);
        else passed++;
        tick();
        sdram_readdatavalid = 0;
    endtask

    task automatic test_hold();
        p1_write = 1; p1_address = 25'h0155; p1_writedata = 16'hBEEF;
        sdram_waitrequest = 1;
        #1;
        checks++;
        if ({sdram_write, sdram_address, p0_waitrequest, p1_waitrequest} !== {1'b1, 25'h0155, 2'b11})
            $display("FAIL hold_c0: got wr=%b addr=%h w=%b expected wr=1 addr=155 w=11", sdram_write, sdram_address, {p0_waitrequest, p1_waitrequest});
        else passed++;
        tick();
        p0_read = 1; p0_address = 25'h0AAA;
        for (int k = 1; k <= 3; k++) begin
            if (k == 3) sdram_waitrequest = 0;
            #1;
            checks++;
            if ({sdram_write, sdram_address, p0_waitrequest, p1_waitrequest} !== {1'b1, 25'h0155, 1'b1, (k != 3)})
                $display("FAIL hold_c%0d: got wr=%b addr=%h w=%b expected wr=1 addr=155 w=1%b", k, sdram_write, sdram_address, {p0_waitrequest, p1_waitrequest}, k != 3);
            else passed++;
            tick();
        end
        p1_write = 0;
        #1;
        checks++;
        if ({sdram_read, sdram_address, p0_waitrequest} !== {1'b1, 25'h0AAA, 1'b0})
            $display("FAIL hold_after: got rd=%b addr=%h w0=%b expected rd=1 addr=aaa w0=0", sdram_read, sdram_address, p0_waitrequest);
        else passed++;
        tick();
        p0_read = 0;
    endtask

    task automatic test_full();
        drain();
        p0_read = 1;
        for (int k = 0; k < 4; k++) begin
            p0_address = 25'(k);
            #1;
            checks++;
            if (p0_waitrequest !== 1'b0)
                $display("FAIL full_rd%0d: got waitrequest=%b expected 0", k, p0_waitrequest);
            else passed++;
            tick();
        end
        p0_address = 25'd4; p1_write = 1;
        #1;
        checks++;
        if ({p0_waitrequest, p1_waitrequest, sdram_write} !== 3'b101)
            $display("FAIL full_block: got w0/w1/wr=%b expected 101", {p0_waitrequest, p1_waitrequest, sdram_write});
        else passed++;
        tick();
        p1_write = 0; sdram_readdatavalid = 1;
        #1;
        checks++;
        if ({p0_waitrequest, sdram_chipselect, p0_readdatavalid} !== 3'b101)
            $display("FAIL full_pop_same: got w0/cs/v0=%b expected 101", {p0_waitrequest, sdram_chipselect, p0_readdatavalid});
        else passed++;
        tick();
        sdram_readdatavalid = 0;
        #1;
        checks++;
        if ({p0_waitrequest, sdram_read, sdram_address} !== {2'b01, 25'd4})
            $display("FAIL full_release: got w0=%b rd=%b addr=%h expected w0=0 rd=1 addr=4", p0_waitrequest, sdram_read, sdram_address);
        else passed++;
        tick();
        p0_read = 0;
    endtask

    task automatic test_interleave();
        bit          who [3];
        logic [15:0] d [3];
        who[0] = 0; who[1] = 1; who[2] = 0;
        drain();
        for (int k = 0; k < 3; k++) begin
            p0_read = !who[k]; p1_read = who[k];
            d[k] = 16'($urandom);
            tick();
        end
        p0_read = 0; p1_read = 0;
        tick();
        for (int k = 0; k < 3; k++) begin
            sdram_readdata = d[k]; sdram_readdatavalid = 1;
            #1;
            checks++;
            if ({p0_readdatavalid, p1_readdatavalid} !== {!who[k], who[k]} ||
                (who[k] ? p1_readdata : p0_readdata) !== d[k])
                $display("FAIL interleave_beat%0d: got v=%b d0=%h d1=%h expected port %0d data %h", k, {p0_readdatavalid, p1_readdatavalid}, p0_readdata, p1_readdata, who[k], d[k]);
            else passed++;
            tick();
        end
        sdram_readdatavalid = 0;
    endtask

    task automatic test_orphan();
        drain();
        sdram_readdatavalid = 1;
        #1;
        checks++;
        if ({p0_readdatavalid, p1_readdatavalid, rd_orphan} !== 3'b000)
            $display("FAIL orphan_strobe: got v0/v1/orphan=%b expected 000", {p0_readdatavalid, p1_readdatavalid, rd_orphan});
        else passed++;
        tick();
        sdram_readdatavalid = 0;
        #1;
        checks++;
        if (rd_orphan !== 1'b1) $display("FAIL orphan_set: got %b expected 1", rd_orphan);
        else passed++;
        tick();
        tick();
        checks++;
        if (rd_orphan !== 1'b1) $display("FAIL orphan_sticky: got %b expected 1", rd_orphan);
        else passed++;
        reset = 0;
        #1;
        checks++;
        if (rd_orphan !== 1'b0) $display("FAIL orphan_clear: got %b expected 0", rd_orphan);
        else passed++;
        m_rst();
        tick();
        reset = 1;
        tick();
    endtask

    task automatic test_reset_hold();
        p0_read = 1; p1_read = 1;
        tick();
        p0_read = 0;
        tick();
        p1_read = 0;
        p0_write = 1; p0_address = 25'h1234; sdram_waitrequest = 1;
        tick();
        p1_write = 1; p1_address = 25'h0777;
        #1;
        checks++;
        if ({sdram_write, sdram_address, p0_waitrequest} !== {1'b1, 25'h1234, 1'b1})
            $display("FAIL rhold_locked: got wr=%b addr=%h w0=%b expected wr=1 addr=1234 w0=1", sdram_write, sdram_address, p0_waitrequest);
        else passed++;
        reset = 0;
        #1;
        checks++;
        if ({sdram_chipselect, sdram_read, sdram_write, sdram_address, p0_waitrequest, p1_waitrequest} !== {28'd0, 2'b11})
            $display("FAIL rhold_async: got cs=%b addr=%h w=%b expected cs=0 addr=0 w=11", sdram_chipselect, sdram_address, {p0_waitrequest, p1_waitrequest});
        else passed++;
        m_rst();
        tick();
        reset = 1; sdram_waitrequest = 0;
        for (int k = 0; k < 4; k++) begin
            bit w;
            w = RR ? bit'(k % 2) : 1'b0;
            #1;
            checks++;
            if ({p0_waitrequest, p1_waitrequest} !== (w ? 2'b10 : 2'b01))
                $display("FAIL rhold_alt%0d: got w0/w1=%b expected port %0d granted", k, {p0_waitrequest, p1_waitrequest}, w);
            else passed++;
            tick();
        end
        p0_write = 0; p1_write = 0; sdram_readdatavalid = 1;
        tick();
        sdram_readdatavalid = 0;
        #1;
        checks++;
        if (rd_orphan !== 1'b1) $display("FAIL rhold_late_beat: got orphan=%b expected 1", rd_orphan);
        else passed++;
        reset = 0;
        m_rst();
        tick();
        reset = 1;
        tick();
    endtask

    task automatic test_random();
        logic [45:0] exp_cmd, got_cmd;
        bit          acc0, acc1, h0, h1;
        for (int i = 0; i < 600; i++) begin
            if (!(p0_read || p0_write)) begin
                int r = int'($urandom_range(0, 9));
                p0_read = r inside {[3:6], 9}; p0_write = r inside {[7:9]};
                p0_address = 25'($urandom); p0_byteenable = 2'($urandom); p0_writedata = 16'($urandom);
            end
            if (!(p1_read || p1_write)) begin
                int r = int'($urandom_range(0, 9));
                p1_read = r inside {[3:6], 9}; p1_write = r inside {[7:9]};
                p1_address = 25'($urandom); p1_byteenable = 2'($urandom); p1_writedata = 16'($urandom);
            end
            sdram_waitrequest = ($urandom_range(0, 3) == 0);
            sdram_readdatavalid = ($urandom_range(0, 2) == 0) && (m_q.size() > 0 || $urandom_range(0, 49) == 0);
            sdram_readdata = 16'($urandom);
            #1;
            m_eval();
            exp_cmd = e_act ? {1'b1, !e_wr, e_wr,
                               e_win ? p1_address : p0_address,
                               e_win ? p1_byteenable : p0_byteenable,
                               e_win ? p1_writedata : p0_writedata} : '0;
            got_cmd = {sdram_chipselect, sdram_read, sdram_write, sdram_address, sdram_byteenable, sdram_writedata};
            acc0 = e_act && !e_win && !sdram_waitrequest;
            acc1 = e_act && e_win && !sdram_waitrequest;
            h0 = sdram_readdatavalid && m_q.size() > 0 && m_q[0] == 1'b0;
            h1 = sdram_readdatavalid && m_q.size() > 0 && m_q[0] == 1'b1;
            checks++;
            if (got_cmd !== exp_cmd) $display("FAIL rand_cmd@%0d: got %h expected %h", i, got_cmd, exp_cmd);
            else passed++;
            checks++;
            if ({p0_waitrequest, p1_waitrequest} !== {!acc0, !acc1})
                $display("FAIL rand_wait@%0d: got %b expected %b", i, {p0_waitrequest, p1_waitrequest}, {!acc0, !acc1});
            else passed++;
            checks++;
            if ({p0_readdatavalid, p1_readdatavalid} !== {h0, h1} || p0_readdata !== sdram_readdata)
                $display("FAIL rand_rdv@%0d: got %b expected %b", i, {p0_readdatavalid, p1_readdatavalid}, {h0, h1});
            else passed++;
            checks++;
            if (rd_orphan !== m_orphan) $display("FAIL rand_orphan@%0d: got %b expected %b", i, rd_orphan, m_orphan);
            else passed++;
            tick();
            if (acc0) begin p0_read = 0; p0_write = 0; end
            if (acc1) begin p1_read = 0; p1_write = 0; end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_full();
        test_interleave();
        test_orphan();
        test_reset_hold();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
